// File: rtl/ice51_mem_arb_pkg.sv
// ice51 unified memory: shared types and address mapping.
// Port indices, port-select type and physical address / range helper.
package ice51_mem_pkg;

  typedef logic [1:0] port_sel_t;

  localparam port_sel_t PORT_CODE = 2'd0;
  localparam port_sel_t PORT_DATA = 2'd1;
  localparam port_sel_t PORT_DBG  = 2'd2;

  typedef struct packed {
    logic        err;
    logic [31:0] phys;
  } map_t;

  function automatic map_t map_addr(
    input logic [31:0] base,
    input logic [31:0] addr,
    input logic [31:0] depth
  );
    map_t m;
    m.phys = base + addr;
    m.err  = (m.phys >= depth);
    return m;
  endfunction

endpackage

// File: rtl/ice51_mem_arb_if.sv
// ice51 unified memory: requester-side bus for code, data and debug.
// master = requesters (core / loader), slave = arbiter.
interface ice51_mem_arb_if #(
  parameter int DATA_W  = 8,
  parameter int AW      = 10,
  parameter int CODE_AW = 9,
  parameter int DATA_AW = 9
);

  logic               i_code_req;
  logic [CODE_AW-1:0] i_code_addr;
  logic               o_code_ack;
  logic               o_code_rvalid;
  logic [DATA_W-1:0]  o_code_rdata;
  logic               o_code_err;

  logic               i_data_req;
  logic               i_data_we;
  logic [DATA_AW-1:0] i_data_addr;
  logic [DATA_W-1:0]  i_data_wdata;
  logic               o_data_ack;
  logic               o_data_rvalid;
  logic [DATA_W-1:0]  o_data_rdata;
  logic               o_data_err;

  logic               i_dbg_req;
  logic               i_dbg_we;
  logic [AW-1:0]      i_dbg_addr;
  logic [DATA_W-1:0]  i_dbg_wdata;
  logic               o_dbg_ack;
  logic               o_dbg_rvalid;
  logic [DATA_W-1:0]  o_dbg_rdata;
  logic               o_dbg_err;

  modport master (
    output i_code_req, i_code_addr,
    input  o_code_ack, o_code_rvalid,
    input  o_code_rdata, o_code_err,
    output i_data_req, i_data_we,
    output i_data_addr, i_data_wdata,
    input  o_data_ack, o_data_rvalid,
    input  o_data_rdata, o_data_err,
    output i_dbg_req, i_dbg_we,
    output i_dbg_addr, i_dbg_wdata,
    input  o_dbg_ack, o_dbg_rvalid,
    input  o_dbg_rdata, o_dbg_err
  );

  modport slave (
    input  i_code_req, i_code_addr,
    output o_code_ack, o_code_rvalid,
    output o_code_rdata, o_code_err,
    input  i_data_req, i_data_we,
    input  i_data_addr, i_data_wdata,
    output o_data_ack, o_data_rvalid,
    output o_data_rdata, o_data_err,
    input  i_dbg_req, i_dbg_we,
    input  i_dbg_addr, i_dbg_wdata,
    output o_dbg_ack, o_dbg_rvalid,
    output o_dbg_rdata, o_dbg_err
  );

endinterface

// File: rtl/ice51_mem_arb_ram.sv
// ice51 unified memory: DATA_W x DEPTH synchronous single-port RAM.
// Read-before-write, one cycle read latency, no reset on contents.
module ice51_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
    o_rdata <= mem[i_addr];
  end

endmodule

// File: rtl/ice51_mem_arb.sv
// ice51 unified memory: 3-port arbiter over one shared RAM.
// DBG strict priority, CODE/DATA round-robin, registered responses.
module ice51_mem_arb
  import ice51_mem_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 1024,
  parameter int AW        = 10,
  parameter int CODE_AW   = 9,
  parameter int DATA_AW   = 9,
  parameter int DATA_BASE = 512
) (
  input logic            i_clk,
  input logic            i_nrst,
  ice51_mem_arb_if.slave bus
);

  logic g_code;
  logic g_data;
  logic g_dbg;
  logic last_data;

  always_comb begin
    g_dbg  = bus.i_dbg_req;
    g_code = !bus.i_dbg_req && bus.i_code_req
             && (!bus.i_data_req || last_data);
    g_data = !bus.i_dbg_req && bus.i_data_req
             && (!bus.i_code_req || !last_data);
  end

  assign bus.o_code_ack = g_code;
  assign bus.o_data_ack = g_data;
  assign bus.o_dbg_ack  = g_dbg;

  map_t code_m;
  map_t data_m;
  map_t dbg_m;
  map_t sel_m;

  assign code_m = map_addr(32'd0,
                           32'(bus.i_code_addr),
                           32'(DEPTH));
  assign data_m = map_addr(32'(DATA_BASE),
                           32'(bus.i_data_addr),
                           32'(DEPTH));
  assign dbg_m  = map_addr(32'd0,
                           32'(bus.i_dbg_addr),
                           32'(DEPTH));

  port_sel_t         sel_port;
  logic              sel_vld;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    sel_vld   = 1'b1;
    sel_port  = PORT_CODE;
    sel_we    = 1'b0;
    sel_wdata = '0;
    sel_m     = code_m;
    unique case (1'b1)
      g_dbg: begin
        sel_port  = PORT_DBG;
        sel_we    = bus.i_dbg_we;
        sel_wdata = bus.i_dbg_wdata;
        sel_m     = dbg_m;
      end
      g_data: begin
        sel_port  = PORT_DATA;
        sel_we    = bus.i_data_we;
        sel_wdata = bus.i_data_wdata;
        sel_m     = data_m;
      end
      g_code: begin
        sel_port  = PORT_CODE;
      end
      default: sel_vld = 1'b0;
    endcase
  end

  // upper phys bits set always means beyond DEPTH (DEPTH = 2**AW)
  logic oob;
  assign oob = sel_m.err | (|sel_m.phys[31:AW]);

  logic [DATA_W-1:0] ram_q;

  ice51_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (sel_vld & sel_we & ~oob),
    .i_addr  (sel_m.phys[AW-1:0]),
    .i_wdata (sel_wdata),
    .o_rdata (ram_q)
  );

  logic [2:0]        hit;
  logic [2:0]        rv;
  logic [2:0]        er;
  logic [2:0]        rd;
  logic [DATA_W-1:0] hold  [3];
  logic [DATA_W-1:0] rdata [3];

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      hit[p] = sel_vld
               && (sel_port == port_sel_t'(p));
    end
  end

  // read responses steer RAM output; otherwise hold last value
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdata[p] = hold[p];
      if (rd[p]) rdata[p] = er[p] ? '0 : ram_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rv        <= '0;
      er        <= '0;
      rd        <= '0;
      last_data <= 1'b0;
      for (int p = 0; p < 3; p++) hold[p] <= '0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        rv[p] <= hit[p];
        er[p] <= hit[p] && oob;
        rd[p] <= hit[p] && !sel_we;
        if (rd[p]) hold[p] <= rdata[p];
      end
      if (g_code)      last_data <= 1'b0;
      else if (g_data) last_data <= 1'b1;
    end
  end

  assign bus.o_code_rvalid = rv[PORT_CODE];
  assign bus.o_code_err    = er[PORT_CODE];
  assign bus.o_code_rdata  = rdata[PORT_CODE];
  assign bus.o_data_rvalid = rv[PORT_DATA];
  assign bus.o_data_err    = er[PORT_DATA];
  assign bus.o_data_rdata  = rdata[PORT_DATA];
  assign bus.o_dbg_rvalid  = rv[PORT_DBG];
  assign bus.o_dbg_err     = er[PORT_DBG];
  assign bus.o_dbg_rdata   = rdata[PORT_DBG];

endmodule

// File: tb/tb_ice51_mem_arb.sv
// ice51 unified memory bench: directed scenarios plus random traffic.
// u_dut uses DATA_BASE=512, u_dut2 uses DATA_BASE=768.
module tb_ice51_mem_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ice51_mem_arb_if bus ();
  ice51_mem_arb_if bus2 ();

  ice51_mem_arb #(.DATA_BASE(512)) u_dut (
    .i_clk  (clk),
    .i_nrst (rst_n),
    .bus    (bus)
  );

  ice51_mem_arb #(.DATA_BASE(768)) u_dut2 (
    .i_clk  (clk),
    .i_nrst (rst_n),
    .bus    (bus2)
  );

  task automatic idle();
    bus.i_code_req = 0;  bus.i_code_addr = '0;
    bus.i_data_req = 0;  bus.i_data_we = 0;
    bus.i_data_addr = '0; bus.i_data_wdata = '0;
    bus.i_dbg_req = 0;   bus.i_dbg_we = 0;
    bus.i_dbg_addr = '0; bus.i_dbg_wdata = '0;
    bus2.i_code_req = 0;  bus2.i_code_addr = '0;
    bus2.i_data_req = 0;  bus2.i_data_we = 0;
    bus2.i_data_addr = '0; bus2.i_data_wdata = '0;
    bus2.i_dbg_req = 0;   bus2.i_dbg_we = 0;
    bus2.i_dbg_addr = '0; bus2.i_dbg_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    #2 rst_n = 0;
    tick();
    n_tests++;
    if ({bus.o_code_rvalid, bus.o_data_rvalid,
         bus.o_dbg_rvalid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_rvalid got %b want 000",
        {bus.o_code_rvalid, bus.o_data_rvalid,
         bus.o_dbg_rvalid});
    end
    n_tests++;
    if ({bus.o_code_rdata, bus.o_data_rdata,
         bus.o_dbg_rdata} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_rdata got %h want 0",
        {bus.o_code_rdata, bus.o_data_rdata,
         bus.o_dbg_rdata});
    end
    n_tests++;
    if ({bus.o_code_err, bus.o_data_err,
         bus.o_dbg_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_err got %b want 000",
        {bus.o_code_err, bus.o_data_err, bus.o_dbg_err});
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_data_rw();
    reset_dut();
    bus.i_data_req = 1; bus.i_data_we = 1;
    bus.i_data_addr = 9'h005; bus.i_data_wdata = 8'hA5;
    #1;
    n_tests++;
    if (bus.o_data_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_ack got %b want 1", bus.o_data_ack);
    end
    tick();
    n_tests++;
    if ({bus.o_data_rvalid, bus.o_data_err,
         bus.o_data_rdata} !== {2'b10, 8'h00}) begin
      n_fail++;
      $display("FAIL wr_rsp got %b/%b/%h want 1/0/00",
        bus.o_data_rvalid, bus.o_data_err, bus.o_data_rdata);
    end
    bus.i_data_we = 0;
    #1;
    n_tests++;
    if (bus.o_data_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_ack got %b want 1", bus.o_data_ack);
    end
    tick();
    n_tests++;
    if ({bus.o_data_rvalid, bus.o_data_err,
         bus.o_data_rdata} !== {2'b10, 8'hA5}) begin
      n_fail++;
      $display("FAIL rd_rsp got %b/%b/%h want 1/0/a5",
        bus.o_data_rvalid, bus.o_data_err, bus.o_data_rdata);
    end
    bus.i_data_req = 0;
    bus.i_dbg_req = 1; bus.i_dbg_addr = 10'h205;
    tick();
    bus.i_dbg_req = 0;
    n_tests++;
    if ({bus.o_dbg_rvalid, bus.o_dbg_rdata} !== {1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL dbg_base got %b/%h want 1/a5",
        bus.o_dbg_rvalid, bus.o_dbg_rdata);
    end
    n_tests++;
    if ({bus.o_data_rvalid, bus.o_data_rdata} !== {1'b0, 8'hA5}) begin
      n_fail++;
      $display("FAIL isolate got %b/%h want 0/a5",
        bus.o_data_rvalid, bus.o_data_rdata);
    end
    idle();
  endtask

  task automatic test_contention();
    logic [1:0] prev;
    logic [1:0] want;
    reset_dut();
    bus.i_code_req = 1; bus.i_code_addr = 9'h011;
    bus.i_data_req = 1; bus.i_data_addr = 9'h022;
    prev = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1;
      want = (i % 2 == 0) ? 2'b10 : 2'b01;
      n_tests++;
      if ({bus.o_data_ack, bus.o_code_ack} !== want) begin
        n_fail++;
        $display("FAIL rr_ack[%0d] got %b want %b (data,code)",
          i, {bus.o_data_ack, bus.o_code_ack}, want);
      end
      n_tests++;
      if ({bus.o_data_rvalid, bus.o_code_rvalid} !== prev) begin
        n_fail++;
        $display("FAIL rr_rv[%0d] got %b want %b",
          i, {bus.o_data_rvalid, bus.o_code_rvalid}, prev);
      end
      prev = want;
      tick();
    end
    n_tests++;
    if ({bus.o_data_rvalid, bus.o_code_rvalid} !== prev) begin
      n_fail++;
      $display("FAIL rr_rv_last got %b want %b",
        {bus.o_data_rvalid, bus.o_code_rvalid}, prev);
    end
  endtask

  // continues from contention: last CODE/DATA grant was CODE
  task automatic test_priority();
    bus.i_dbg_req = 1; bus.i_dbg_addr = 10'h001;
    #1;
    n_tests++;
    if ({bus.o_dbg_ack, bus.o_data_ack,
         bus.o_code_ack} !== 3'b100) begin
      n_fail++;
      $display("FAIL prio_dbg got %b want 100",
        {bus.o_dbg_ack, bus.o_data_ack, bus.o_code_ack});
    end
    tick();
    bus.i_dbg_req = 0;
    #1;
    n_tests++;
    if ({bus.o_dbg_ack, bus.o_data_ack,
         bus.o_code_ack} !== 3'b010) begin
      n_fail++;
      $display("FAIL prio_rr got %b want 010",
        {bus.o_dbg_ack, bus.o_data_ack, bus.o_code_ack});
    end
    n_tests++;
    if (bus.o_dbg_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_rv got %b want 1", bus.o_dbg_rvalid);
    end
    tick();
    bus.i_dbg_req = 1;
    tick();
    bus.i_dbg_req = 0;
    #1;
    n_tests++;
    if ({bus.o_data_ack, bus.o_code_ack} !== 2'b01) begin
      n_fail++;
      $display("FAIL prio_ptr got %b want 01",
        {bus.o_data_ack, bus.o_code_ack});
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_raw();
    bus.i_dbg_req = 1; bus.i_dbg_we = 1;
    bus.i_dbg_addr = 10'h010; bus.i_dbg_wdata = 8'h3C;
    tick();
    bus.i_dbg_req = 0; bus.i_dbg_we = 0;
    bus.i_code_req = 1; bus.i_code_addr = 9'h010;
    #1;
    n_tests++;
    if (bus.o_code_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_ack got %b want 1", bus.o_code_ack);
    end
    tick();
    bus.i_code_req = 0;
    n_tests++;
    if ({bus.o_code_rvalid, bus.o_code_err,
         bus.o_code_rdata} !== {2'b10, 8'h3C}) begin
      n_fail++;
      $display("FAIL raw_rsp got %b/%b/%h want 1/0/3c",
        bus.o_code_rvalid, bus.o_code_err, bus.o_code_rdata);
    end
    idle();
  endtask

  task automatic test_range();
    bus2.i_dbg_req = 1; bus2.i_dbg_we = 1;
    bus2.i_dbg_addr = 10'h000; bus2.i_dbg_wdata = 8'h11;
    tick();
    bus2.i_dbg_req = 0; bus2.i_dbg_we = 0;
    bus2.i_data_req = 1; bus2.i_data_we = 1;
    bus2.i_data_addr = 9'h0FF; bus2.i_data_wdata = 8'h77;
    tick();
    n_tests++;
    if ({bus2.o_data_rvalid, bus2.o_data_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL edge_wr got %b want 10",
        {bus2.o_data_rvalid, bus2.o_data_err});
    end
    bus2.i_data_addr = 9'h100; bus2.i_data_wdata = 8'hEE;
    #1;
    n_tests++;
    if (bus2.o_data_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_ack got %b want 1", bus2.o_data_ack);
    end
    tick();
    n_tests++;
    if ({bus2.o_data_rvalid, bus2.o_data_err} !== 2'b11) begin
      n_fail++;
      $display("FAIL oob_wr got %b want 11",
        {bus2.o_data_rvalid, bus2.o_data_err});
    end
    bus2.i_data_we = 0;
    tick();
    n_tests++;
    if ({bus2.o_data_rvalid, bus2.o_data_err,
         bus2.o_data_rdata} !== {2'b11, 8'h00}) begin
      n_fail++;
      $display("FAIL oob_rd got %b/%b/%h want 1/1/00",
        bus2.o_data_rvalid, bus2.o_data_err, bus2.o_data_rdata);
    end
    bus2.i_data_addr = 9'h0FF;
    tick();
    n_tests++;
    if ({bus2.o_data_rvalid, bus2.o_data_err,
         bus2.o_data_rdata} !== {2'b10, 8'h77}) begin
      n_fail++;
      $display("FAIL edge_rd got %b/%b/%h want 1/0/77",
        bus2.o_data_rvalid, bus2.o_data_err, bus2.o_data_rdata);
    end
    bus2.i_data_req = 0;
    bus2.i_dbg_req = 1; bus2.i_dbg_addr = 10'h000;
    tick();
    n_tests++;
    if (bus2.o_dbg_rdata !== 8'h11) begin
      n_fail++;
      $display("FAIL oob_drop got %h want 11", bus2.o_dbg_rdata);
    end
    bus2.i_dbg_addr = 10'h3FF;
    tick();
    n_tests++;
    if (bus2.o_dbg_rdata !== 8'h77) begin
      n_fail++;
      $display("FAIL edge_map got %h want 77", bus2.o_dbg_rdata);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    bus.i_code_req = 1; bus.i_code_addr = 9'h010;
    #1;
    n_tests++;
    if (bus.o_code_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_ack got %b want 1", bus.o_code_ack);
    end
    rst_n = 0;
    tick();
    idle();
    n_tests++;
    if ({bus.o_code_rvalid, bus.o_code_err,
         bus.o_code_rdata} !== {2'b00, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_rsp got %b/%b/%h want 0/0/00",
        bus.o_code_rvalid, bus.o_code_err, bus.o_code_rdata);
    end
    rst_n = 1;
    tick();
    bus.i_code_req = 1; bus.i_data_req = 1;
    #1;
    n_tests++;
    if ({bus.o_data_ack, bus.o_code_ack} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_rr got %b want 10",
        {bus.o_data_ack, bus.o_code_ack});
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [7:0] mem [1024];
    logic [7:0] hold [3];
    bit         pend [3];
    bit         we [3];
    int         addr [3];
    logic [7:0] wd [3];
    int         last;
    int         g;
    int         phys;
    logic [2:0] exp_ack;
    logic [2:0] obs_rv;
    logic [2:0] obs_er;
    logic [7:0] obs_rd [3];

    reset_dut();
    bus.i_dbg_req = 1; bus.i_dbg_we = 1;
    for (int a = 0; a < 1024; a++) begin
      mem[a] = 8'($urandom);
      bus.i_dbg_addr = 10'(a);
      bus.i_dbg_wdata = mem[a];
      tick();
    end
    idle();
    tick();
    last = 0;
    for (int p = 0; p < 3; p++) begin
      hold[p] = 8'h00;
      pend[p] = 0;
    end

    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 3; p++) begin
        if (pend[p] && $urandom_range(0, 15) == 0) pend[p] = 0;
        else if (!pend[p]
                 && $urandom_range(0, (p == 2) ? 7 : 1) == 0) begin
          pend[p] = 1;
          we[p]   = (p != 0) && $urandom_range(0, 1) == 1;
          addr[p] = $urandom_range(0, (p == 2) ? 1023 : 511);
          wd[p]   = 8'($urandom);
        end
      end
      bus.i_code_req = pend[0]; bus.i_code_addr = 9'(addr[0]);
      bus.i_data_req = pend[1]; bus.i_data_we = we[1];
      bus.i_data_addr = 9'(addr[1]); bus.i_data_wdata = wd[1];
      bus.i_dbg_req = pend[2]; bus.i_dbg_we = we[2];
      bus.i_dbg_addr = 10'(addr[2]); bus.i_dbg_wdata = wd[2];
      #1;

      if (pend[2])                g = 2;
      else if (pend[0] && pend[1]) g = (last == 0) ? 1 : 0;
      else if (pend[0])           g = 0;
      else if (pend[1])           g = 1;
      else                        g = -1;
      exp_ack = (g < 0) ? 3'b000 : 3'(1 << g);
      n_tests++;
      if ({bus.o_dbg_ack, bus.o_data_ack,
           bus.o_code_ack} !== exp_ack) begin
        n_fail++;
        $display("FAIL rnd_ack[%0d] got %b want %b", c,
          {bus.o_dbg_ack, bus.o_data_ack, bus.o_code_ack}, exp_ack);
      end
      if (g >= 0) begin
        phys = (g == 1) ? 512 + addr[g] : addr[g];
        if (we[g]) mem[phys] = wd[g];
        else       hold[g] = mem[phys];
        if (g < 2) last = g;
        pend[g] = 0;
      end
      tick();

      obs_rv = {bus.o_dbg_rvalid, bus.o_data_rvalid,
                bus.o_code_rvalid};
      obs_er = {bus.o_dbg_err, bus.o_data_err, bus.o_code_err};
      obs_rd[0] = bus.o_code_rdata;
      obs_rd[1] = bus.o_data_rdata;
      obs_rd[2] = bus.o_dbg_rdata;
      for (int p = 0; p < 3; p++) begin
        n_tests++;
        if ({obs_rv[p], obs_er[p], obs_rd[p]}
            !== {exp_ack[p], 1'b0, hold[p]}) begin
          n_fail++;
          $display("FAIL rnd_rsp[%0d] p%0d got %b/%b/%h want %b/0/%h",
            c, p, obs_rv[p], obs_er[p], obs_rd[p],
            exp_ack[p], hold[p]);
        end
      end
    end
    idle();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    test_reset();
    test_data_rw();
    test_contention();
    test_priority();
    test_raw();
    test_range();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
